// File: rtl/mem_wb_elastic_reg_if.sv
// Stage bus for the MEM/WB elastic register: one valid/ready handshake plus
// the instruction payload that travels with it. One instance carries the
// MEM-side input and a second carries the WB-side head entry.
interface mem_wb_elastic_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  Valid;
    logic                  Ready;
    logic                  MemoryToReg;
    logic                  RegWrite;
    logic                  PCEight;
    logic [DATA_W-1:0]     AluResult;
    logic [DATA_W-1:0]     DataMemoryResult;
    logic [DATA_W-1:0]     PCAddResult;
    logic [REG_ADDR_W-1:0] WriteRegister;

    // Producer drives valid and payload, consumer answers with ready.
    modport master (
        output Valid, MemoryToReg, RegWrite, PCEight,
               AluResult, DataMemoryResult, PCAddResult, WriteRegister,
        input  Ready
    );

    modport slave (
        input  Valid, MemoryToReg, RegWrite, PCEight,
               AluResult, DataMemoryResult, PCAddResult, WriteRegister,
        output Ready
    );
endinterface

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB elastic pipeline register: head entry plus one skid entry, a
// registered MEM-side ready, synchronous flush, the write-back data mux and
// the gated register-file write strobe.
// The mem_in bus carries the MEM_* / *In signals (MEM_Valid, MEM_Ready, ...);
// the wb_out bus carries the WB_* / *Out head-entry signals.
// Optional feature: define RETIRE_CNT_EN to add the RetireCount output.
module mem_wb_elastic_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Flush,
    mem_wb_elastic_reg_if.slave  mem_in,
    mem_wb_elastic_reg_if.master wb_out,
    output logic [DATA_W-1:0]   WB_WriteData,
    output logic                WB_RegWriteEn
`ifdef RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]    RetireCount
`endif
);

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  pc_eight;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     dmem;
        logic [DATA_W-1:0]     pc_add;
        logic [REG_ADDR_W-1:0] wreg;
    } entry_t;

    entry_t in_s;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;
    logic   accept_s;
    logic   retire_s;

    // Gather the incoming MEM-stage payload into one entry.
    always_comb begin
        in_s.mem_to_reg = mem_in.MemoryToReg;
        in_s.reg_write  = mem_in.RegWrite;
        in_s.pc_eight   = mem_in.PCEight;
        in_s.alu        = mem_in.AluResult;
        in_s.dmem       = mem_in.DataMemoryResult;
        in_s.pc_add     = mem_in.PCAddResult;
        in_s.wreg       = mem_in.WriteRegister;
    end

    assign accept_s = mem_in.Valid & ready_q;
    assign retire_s = head_valid_q & wb_out.Ready;

    // Next-state for both entries; payload moves only on a real load, flush
    // touches nothing but the valid bits.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (head_valid_q) begin
            if (retire_s) begin
                if (skid_valid_q) begin
                    head_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (accept_s) begin
                    head_d = in_s;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (accept_s) begin
                skid_d       = in_s;
                skid_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b1;
            end
        end else if (accept_s) begin
            head_d       = in_s;
            head_valid_d = 1'b1;
        end else begin
            head_valid_d = 1'b0;
        end

        if (Flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            skid_valid_d = skid_valid_d & head_valid_d;
        end

        // Ready is a flop so it never depends combinationally on WB ready.
        ready_d = ~skid_valid_d;
    end

    // Entry state and ready registers; async reset clears everything.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign mem_in.Ready            = ready_q;
    assign wb_out.Valid            = head_valid_q;
    assign wb_out.MemoryToReg      = head_q.mem_to_reg;
    assign wb_out.RegWrite         = head_q.reg_write;
    assign wb_out.PCEight          = head_q.pc_eight;
    assign wb_out.AluResult        = head_q.alu;
    assign wb_out.DataMemoryResult = head_q.dmem;
    assign wb_out.PCAddResult      = head_q.pc_add;
    assign wb_out.WriteRegister    = head_q.wreg;

    // Write-back value: link address beats load data beats ALU result.
    always_comb begin
        if (head_q.pc_eight) begin
            WB_WriteData = head_q.pc_add + DATA_W'(4);
        end else if (head_q.mem_to_reg) begin
            WB_WriteData = head_q.dmem;
        end else begin
            WB_WriteData = head_q.alu;
        end
    end

    // Register zero is hard-wired, so writes to it are suppressed here.
    assign WB_RegWriteEn = retire_s & head_q.reg_write &
                           (head_q.wreg != {REG_ADDR_W{1'b0}});

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count every retire, including one that coincides with a flush.
    always_comb begin
        if (retire_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Retire counter register, cleared only by reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign RetireCount = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Self-checking bench for mem_wb_elastic_reg: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_mem_wb_elastic_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 32;

    typedef struct {
        logic          m2r;
        logic          rw;
        logic          pc8;
        logic [DW-1:0] alu;
        logic [DW-1:0] dm;
        logic [DW-1:0] pc;
        logic [AW-1:0] wr;
    } ent_t;

    logic          Clk;
    logic          Rst_n;
    logic          Flush;
    logic [DW-1:0] WB_WriteData;
    logic          WB_RegWriteEn;
    logic [CW-1:0] RetireCount;

    mem_wb_elastic_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) mem_if ();
    mem_wb_elastic_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) wb_if ();

    mem_wb_elastic_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Flush         (Flush),
        .mem_in        (mem_if),
        .wb_out        (wb_if),
        .WB_WriteData  (WB_WriteData),
        .WB_RegWriteEn (WB_RegWriteEn)
`ifdef RETIRE_CNT_EN
        ,
        .RetireCount   (RetireCount)
`endif
    );

`ifndef RETIRE_CNT_EN
    assign RetireCount = '0;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state: FIFO of in-flight instructions, oldest first.
    ent_t          q[$];
    bit            ready_en;
    logic [CW-1:0] retired;
    int            total;
    int            bad;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic [DW-1:0] alu, input logic [DW-1:0] dm,
                                input logic [DW-1:0] pc, input logic m2r, input logic rw,
                                input logic pc8, input logic [AW-1:0] wr);
        ent_t e;
        e.alu = alu; e.dm = dm; e.pc = pc; e.m2r = m2r; e.rw = rw; e.pc8 = pc8; e.wr = wr;
        return e;
    endfunction

    function automatic logic [DW-1:0] wb_value(input ent_t e);
        if (e.pc8) return e.pc + 32'd4;
        if (e.m2r) return e.dm;
        return e.alu;
    endfunction

    // Compare every DUT output against what the model says right now.
    task automatic check_outputs();
        ent_t h;
        logic exp_valid;
        logic exp_ready;
        logic exp_wen;
        exp_valid = (Rst_n === 1'b1) && (q.size() > 0);
        exp_ready = (Rst_n === 1'b1) && ready_en && (q.size() < 2);
        h = exp_valid ? q[0] : mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        exp_wen = exp_valid && wb_if.Ready && h.rw && (h.wr != 5'd0);
        check_val("mem_ready", {63'd0, mem_if.Ready}, {63'd0, exp_ready});
        check_val("wb_valid", {63'd0, wb_if.Valid}, {63'd0, exp_valid});
        check_val("reg_wen", {63'd0, WB_RegWriteEn}, {63'd0, exp_wen});
        if (exp_valid || Rst_n !== 1'b1) begin
            check_val("wdata", {32'd0, WB_WriteData}, {32'd0, wb_value(h)});
            check_val("alu", {32'd0, wb_if.AluResult}, {32'd0, h.alu});
            check_val("dmem", {32'd0, wb_if.DataMemoryResult}, {32'd0, h.dm});
            check_val("pc", {32'd0, wb_if.PCAddResult}, {32'd0, h.pc});
            check_val("wreg", {59'd0, wb_if.WriteRegister}, {59'd0, h.wr});
            check_val("ctrl", {61'd0, wb_if.MemoryToReg, wb_if.RegWrite, wb_if.PCEight},
                      {61'd0, h.m2r, h.rw, h.pc8});
        end
`ifdef RETIRE_CNT_EN
        check_val("retire_cnt", {32'd0, RetireCount}, {32'd0, retired});
`endif
    endtask

    // One clock cycle: drive inputs, check, take the edge, advance the model.
    task automatic cyc(input logic v, input logic wbr, input logic fl, input ent_t e);
        logic acc;
        logic ret;
        mem_if.Valid            = v;
        mem_if.MemoryToReg      = e.m2r;
        mem_if.RegWrite         = e.rw;
        mem_if.PCEight          = e.pc8;
        mem_if.AluResult        = e.alu;
        mem_if.DataMemoryResult = e.dm;
        mem_if.PCAddResult      = e.pc;
        mem_if.WriteRegister    = e.wr;
        wb_if.Ready             = wbr;
        Flush                   = fl;
        #3;
        check_outputs();
        acc = v && (Rst_n === 1'b1) && ready_en && (q.size() < 2);
        ret = (Rst_n === 1'b1) && (q.size() > 0) && wbr;
        @(posedge Clk);
        if (Rst_n !== 1'b1) begin
            q.delete();
            ready_en = 1'b0;
            retired  = '0;
        end else begin
            if (ret) retired = retired + 32'd1;
            if (fl) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            ready_en = 1'b1;
        end
        #1;
    endtask

    ent_t z;
    ent_t r;

    initial begin
        total = 0; bad = 0; ready_en = 1'b0; retired = '0;
        z = mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        Rst_n = 1'b0;
        Flush = 1'b0;
        mem_if.Valid = 1'b0;
        wb_if.Ready = 1'b0;
        #2;
        check_outputs();
        @(posedge Clk); #1;
        cyc(1'b1, 1'b1, 1'b0, mk(32'h55, 32'h66, 32'h77, 1'b0, 1'b1, 1'b0, 5'd3));
        cyc(1'b0, 1'b1, 1'b0, z);
        Rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, mk(32'h99, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd3));

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 1'b0, mk(32'h10 + 32'(i), 32'hDEAD, 32'h0, 1'b0, 1'b1, 1'b0, 5'd3));
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);

        // Backpressure: fill head and skid, then drain in order.
        cyc(1'b1, 1'b0, 1'b0, mk(32'hA, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd4));
        cyc(1'b1, 1'b0, 1'b0, mk(32'hB, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd5));
        cyc(1'b1, 1'b0, 1'b0, mk(32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd6));
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);

        // Flush with a full skid and an offered instruction.
        cyc(1'b1, 1'b0, 1'b0, mk(32'hA, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd4));
        cyc(1'b1, 1'b0, 1'b0, mk(32'hB, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd5));
        cyc(1'b1, 1'b0, 1'b1, mk(32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd6));
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);

        // Flush while retiring and accepting: retire completes, accept is lost.
        cyc(1'b1, 1'b0, 1'b0, mk(32'hE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd7));
        cyc(1'b1, 1'b1, 1'b1, mk(32'hF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd8));
        cyc(1'b0, 1'b1, 1'b0, z);

        // Mux priority and PC+4 wrap, then a write to register zero.
        cyc(1'b1, 1'b1, 1'b0, mk(32'h1, 32'h2, 32'h00400004, 1'b1, 1'b1, 1'b1, 5'd31));
        cyc(1'b1, 1'b1, 1'b0, mk(32'h1, 32'h2, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b1, 5'd31));
        cyc(1'b1, 1'b1, 1'b0, mk(32'h1, 32'h2, 32'h3, 1'b1, 1'b1, 1'b0, 5'd9));
        cyc(1'b1, 1'b1, 1'b0, mk(32'h77, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0));
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);

        // Asynchronous reset in the middle of a stall.
        cyc(1'b1, 1'b0, 1'b0, mk(32'hA, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0, 5'd4));
        cyc(1'b1, 1'b0, 1'b0, mk(32'hB, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0, 5'd5));
        cyc(1'b0, 1'b0, 1'b0, z);
        #2;
        Rst_n = 1'b0;
        q.delete();
        ready_en = 1'b0;
        retired  = '0;
        #1;
        check_outputs();
        @(posedge Clk); #1;
        cyc(1'b1, 1'b1, 1'b0, mk(32'h5, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1));
        Rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, mk(32'h6, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1));

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r = mk($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 15) == 0), r);
        end
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);
        cyc(1'b0, 1'b1, 1'b0, z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
